// File: rtl/pio_uart_pkg.sv
// Shared types and constants for the PIO-to-UART transmitter.
package pio_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/pio_uart_fifo.sv
// Small synchronous FIFO with wrap-around pointers and occupancy count.
module pio_uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rd_q];

  // A push into a full FIFO is still taken when a pop frees the head slot on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/pio_uart_tx.sv
// Change-detecting PIO byte capture feeding an 8N1 UART transmitter through a small FIFO.
module pio_uart_tx
  import pio_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned LevelW      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_port,
  output logic                 tx,
  output logic                 busy,
  output logic                 overflow,
  output logic [LevelW-1:0]    fifo_level
);

  localparam logic [15:0] BaudReload = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LastBit    = 3'(DATA_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [15:0]            baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic [DATA_BITS-1:0]   last_q;
  logic                   overflow_q;
  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;

  assign push = (in_port != last_q);

  pio_uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (in_port),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          tx_d    = 1'b0;
          baud_d  = BaudReload;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          bit_d   = '0;
          tx_d    = shift_q[0];
          baud_d  = BaudReload;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BaudReload;
          if (bit_q == LastBit) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // Shift so the next data bit always sits at bit 0.
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            tx_d    = 1'b0;
            baud_d  = BaudReload;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      last_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      if (push) last_q <= in_port;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_pio_uart_tx.sv
// Scenario and randomized bench for pio_uart_tx against a frame-timing reference model.
module tb_pio_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;
  localparam int          FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_port;
  logic          tx, busy, overflow;
  logic [LW-1:0] fifo_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: pending bytes, current frame byte and the cycle its start bit began.
  logic [7:0] m_last;
  logic [7:0] m_q[$];
  bit         m_active;
  int         m_start;
  logic [7:0] m_byte;
  bit         m_ovf;

  pio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_last   = 8'h00;
    m_q.delete();
    m_active = 1'b0;
    m_start  = 0;
    m_byte   = 8'h00;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] v);
    bit fend, do_pop;
    fend   = m_active && ((cyc - m_start) == FRAME);
    do_pop = (!m_active || fend) && (m_q.size() != 0);
    if (do_pop) begin
      m_byte   = m_q.pop_front();
      m_active = 1'b1;
      m_start  = cyc;
    end else if (fend) begin
      m_active = 1'b0;
    end
    if (v != m_last) begin
      m_last = v;
      if (m_q.size() < DEPTH) m_q.push_back(v);
      else m_ovf = 1'b1;
    end
  endtask

  function automatic logic m_tx();
    int k;
    if (!m_active) return 1'b1;
    k = (cyc - m_start) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  function automatic logic [LW+2:0] m_exp();
    return {m_tx(), (m_active || m_q.size() != 0), m_ovf, LW'(m_q.size())};
  endfunction

  task automatic tick(input logic [7:0] v);
    in_port = v;
    @(posedge clk);
    cyc++;
    model_step(v);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 500) begin
      tick(in_port);
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_timeout: busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    in_port = 8'h00;
    model_reset();
    #1;
    total++;
    if ({tx, busy, overflow, fifo_level} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL reset_async: got %b want %b", {tx, busy, overflow, fifo_level}, 6'b100000);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({tx, busy, overflow, fifo_level} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL reset_held: got %b want %b", {tx, busy, overflow, fifo_level}, 6'b100000);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    bit exp_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int busy_low = -1;
    tick(8'hA5);
    total++;
    if (tx !== 1'b1 || busy !== 1'b1 || fifo_level !== 3'd1) begin
      bad++;
      $display("FAIL single_push: got tx=%b busy=%b lvl=%0d want 1 1 1", tx, busy, fifo_level);
    end
    for (int j = 1; j <= 45; j++) begin
      tick(8'hA5);
      total++;
      if ({tx, busy, overflow, fifo_level} !== m_exp()) begin
        bad++;
        $display("FAIL single_model cyc=%0d: got %b want %b", cyc, {tx, busy, overflow, fifo_level},
                 m_exp());
      end
      if (j <= FRAME) begin
        total++;
        if (tx !== exp_bits[(j-1)/CPB]) begin
          bad++;
          $display("FAIL single_bit j=%0d: got %b want %b", j, tx, exp_bits[(j-1)/CPB]);
        end
      end
      if (busy_low < 0 && busy === 1'b0) busy_low = j;
    end
    total++;
    if (busy_low != 41) begin
      bad++;
      $display("FAIL single_busy_fall: got %0d want 41", busy_low);
    end
  endtask

  task automatic test_static_value();
    int low_cycles = 0;
    tick(8'h3C);
    for (int j = 1; j <= 250; j++) begin
      tick(8'h3C);
      total++;
      if ({tx, busy, overflow, fifo_level} !== m_exp()) begin
        bad++;
        $display("FAIL static_model cyc=%0d: got %b want %b", cyc, {tx, busy, overflow, fifo_level},
                 m_exp());
      end
      if (tx === 1'b0) low_cycles++;
    end
    // 3C = start + four zero data bits low, one frame only.
    total++;
    if (low_cycles != 5 * CPB) begin
      bad++;
      $display("FAIL static_low_cycles: got %0d want %0d", low_cycles, 5 * CPB);
    end
  endtask

  task automatic test_back_to_back();
    int peak = 0;
    int busy_low = -1;
    logic [7:0] seq [3] = '{8'h01, 8'h02, 8'h03};
    wait_idle("b2b");
    for (int j = 0; j <= 130; j++) begin
      tick(j < 3 ? seq[j] : 8'h03);
      total++;
      if ({tx, busy, overflow, fifo_level} !== m_exp()) begin
        bad++;
        $display("FAIL b2b_model cyc=%0d: got %b want %b", cyc, {tx, busy, overflow, fifo_level},
                 m_exp());
      end
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      if (busy_low < 0 && busy === 1'b0) busy_low = j;
    end
    total++;
    if (peak != 2) begin
      bad++;
      $display("FAIL b2b_peak_level: got %0d want 2", peak);
    end
    total++;
    if (busy_low != 121) begin
      bad++;
      $display("FAIL b2b_busy_fall: got %0d want 121", busy_low);
    end
  endtask

  task automatic test_overflow();
    int busy_low = -1;
    wait_idle("ovf");
    for (int j = 0; j <= 230; j++) begin
      tick(j < 6 ? 8'(j + 1) : 8'h06);
      total++;
      if ({tx, busy, overflow, fifo_level} !== m_exp()) begin
        bad++;
        $display("FAIL ovf_model cyc=%0d: got %b want %b", cyc, {tx, busy, overflow, fifo_level},
                 m_exp());
      end
      if (j == 5) begin
        total++;
        if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
          bad++;
          $display("FAIL ovf_flag: got ovf=%b lvl=%0d want 1 4", overflow, fifo_level);
        end
      end
      if (busy_low < 0 && busy === 1'b0) busy_low = j;
    end
    total++;
    if (busy_low != 201) begin
      bad++;
      $display("FAIL ovf_busy_fall (5 frames): got %0d want 201", busy_low);
    end
  endtask

  task automatic test_reset_midframe();
    int busy_low = -1;
    logic [7:0] seq [3] = '{8'h21, 8'h22, 8'h23};
    wait_idle("midrst");
    for (int j = 0; j <= 15; j++) tick(j < 3 ? seq[j] : 8'h23);
    total++;
    if (tx !== m_tx() || fifo_level !== 3'd2 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: got tx=%b lvl=%0d busy=%b want %b 2 1", tx, fifo_level, busy,
               m_tx());
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({tx, busy, overflow, fifo_level} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      bad++;
      $display("FAIL midrst_async: got %b want %b", {tx, busy, overflow, fifo_level}, 6'b100000);
    end
    model_reset();
    in_port = 8'h5A;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int j = 0; j <= 45; j++) begin
      tick(8'h5A);
      total++;
      if ({tx, busy, overflow, fifo_level} !== m_exp()) begin
        bad++;
        $display("FAIL midrst_model cyc=%0d: got %b want %b", cyc, {tx, busy, overflow, fifo_level},
                 m_exp());
      end
      if (busy_low < 0 && busy === 1'b0) busy_low = j;
    end
    total++;
    if (busy_low != 41) begin
      bad++;
      $display("FAIL midrst_one_frame: got %0d want 41", busy_low);
    end
  endtask

  task automatic test_full_coincide();
    wait_idle("coinc");
    for (int j = 0; j <= 41; j++) begin
      tick(j < 5 ? 8'(8'h31 + j) : (j < 41 ? 8'h35 : 8'h36));
      total++;
      if ({tx, busy, overflow, fifo_level} !== m_exp()) begin
        bad++;
        $display("FAIL coinc_model cyc=%0d: got %b want %b", cyc, {tx, busy, overflow, fifo_level},
                 m_exp());
      end
    end
    // Edge 41 is both the end of the first frame and the push of 36.
    total++;
    if (overflow !== 1'b0 || fifo_level !== 3'd4 || tx !== 1'b0) begin
      bad++;
      $display("FAIL coinc_accept: got ovf=%b lvl=%0d tx=%b want 0 4 0", overflow, fifo_level, tx);
    end
    for (int j = 0; j < 210; j++) begin
      tick(8'h36);
      total++;
      if ({tx, busy, overflow, fifo_level} !== m_exp()) begin
        bad++;
        $display("FAIL coinc_drain cyc=%0d: got %b want %b", cyc, {tx, busy, overflow, fifo_level},
                 m_exp());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    v = in_port;
    for (int p = 0; p < 12; p++) begin
      int rate = int'($urandom_range(0, 60));
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, rate) == 0) v = 8'($urandom);
        tick(v);
        total++;
        if ({tx, busy, overflow, fifo_level} !== m_exp()) begin
          bad++;
          $display("FAIL random_model cyc=%0d: got %b want %b", cyc,
                   {tx, busy, overflow, fifo_level}, m_exp());
        end
      end
    end
    wait_idle("random");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_static_value();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_full_coincide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
